pmem_arbiter: RTL and testbench

- Shares the single 256-bit physical-memory port between the instruction cache (read-only line fills) and the data cache (line fills and dirty write-backs).
- Sits between the two caches' pmem-side interfaces and main memory.
- Registers the winning request (op, address, write line) at grant and holds it stable until memory responds.
- Routes the response and read line back only to the granted cache.

---
 rtl/pmem_arb_pkg.sv | 20 ++
 rtl/pmem_arb_grant.sv | 26 ++
 rtl/pmem_arbiter.sv | 112 +++++++++++
 tb/tb_pmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the physical-memory arbiter.
// The optional round-robin mode is enabled with the macro PMEM_ARB_RR_EN.
package pmem_arb_pkg;

    localparam int unsigned PMEM_ADDR_W = 32;
    localparam int unsigned PMEM_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RECOVER
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

endpackage

// File: rtl/pmem_arb_grant.sv
// Combinational grant decision between icache and dcache requests.
// PMEM_ARB_RR_EN: on a tie, grant the side not served last; otherwise dcache always wins.
module pmem_arb_grant (
    input  logic icache_req_i,
    input  logic dcache_req_i,
    input  logic last_dcache_i,
    output logic icache_gnt_o,
    output logic dcache_gnt_o
);

`ifdef PMEM_ARB_RR_EN
    always_comb begin
        dcache_gnt_o = dcache_req_i && !(icache_req_i && last_dcache_i);
        icache_gnt_o = icache_req_i && !dcache_gnt_o;
    end
`else
    logic unused_last;
    assign unused_last = last_dcache_i;

    always_comb begin
        dcache_gnt_o = dcache_req_i;
        icache_gnt_o = icache_req_i && !dcache_req_i;
    end
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one pmem port between icache fills and dcache fills/write-backs.
// PMEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed dcache priority.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = PMEM_ADDR_W,
    parameter int unsigned LINE_W = PMEM_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read_a,
    input  logic [ADDR_W-1:0] pmem_addr_a,
    output logic [LINE_W-1:0] pmem_rdata_a,
    output logic              pmem_resp_a,
    input  logic              pmem_read_d,
    input  logic              pmem_write_d,
    input  logic [ADDR_W-1:0] pmem_addr_d,
    input  logic [LINE_W-1:0] pmem_wdata_d,
    output logic [LINE_W-1:0] pmem_rdata_d,
    output logic              pmem_resp_d,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q;
    arb_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              last_dcache;
    logic              gnt_i, gnt_d;
    logic              busy;

`ifdef PMEM_ARB_RR_EN
    logic last_dcache_q;
    assign last_dcache = last_dcache_q;
`else
    assign last_dcache = 1'b0;
`endif

    pmem_arb_grant u_grant (
        .icache_req_i  (pmem_read_a),
        .dcache_req_i  (pmem_read_d | pmem_write_d),
        .last_dcache_i (last_dcache),
        .icache_gnt_o  (gnt_i),
        .dcache_gnt_o  (gnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef PMEM_ARB_RR_EN
            last_dcache_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_d) begin
                        state_q <= BUSY_D;
                        op_q    <= pmem_write_d ? OP_WRITE : OP_READ;
                        addr_q  <= pmem_addr_d;
                        wdata_q <= pmem_wdata_d;
`ifdef PMEM_ARB_RR_EN
                        last_dcache_q <= 1'b1;
`endif
                    end else if (gnt_i) begin
                        state_q <= BUSY_I;
                        op_q    <= OP_READ;
                        addr_q  <= pmem_addr_a;
                        wdata_q <= '0;
`ifdef PMEM_ARB_RR_EN
                        last_dcache_q <= 1'b0;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (pmem_resp) state_q <= RECOVER;
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign pmem_read    = busy && (op_q == OP_READ);
    assign pmem_write   = busy && (op_q == OP_WRITE);
    assign pmem_address = addr_q;
    // Write data is only presented for write-backs; reads see zero.
    assign pmem_wdata   = pmem_write ? wdata_q : '0;

    assign pmem_resp_a  = (state_q == BUSY_I) && pmem_resp;
    assign pmem_resp_d  = (state_q == BUSY_D) && pmem_resp;
    assign pmem_rdata_a = pmem_resp_a ? pmem_rdata : '0;
    assign pmem_rdata_d = pmem_resp_d ? pmem_rdata : '0;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(pmem_read_d && pmem_write_d))
            else $warning("pmem_arbiter: pmem_read_d and pmem_write_d both high, write issued");
            assert (!(pmem_resp && !busy))
            else $warning("pmem_arbiter: pmem_resp outside a transaction ignored");
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed vector table, corner sequences, random traffic.
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk, rst;
    logic          pmem_read_a, pmem_resp_a;
    logic [AW-1:0] pmem_addr_a;
    logic [LW-1:0] pmem_rdata_a;
    logic          pmem_read_d, pmem_write_d, pmem_resp_d;
    logic [AW-1:0] pmem_addr_d;
    logic [LW-1:0] pmem_wdata_d, pmem_rdata_d;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read_a  (pmem_read_a),
        .pmem_addr_a  (pmem_addr_a),
        .pmem_rdata_a (pmem_rdata_a),
        .pmem_resp_a  (pmem_resp_a),
        .pmem_read_d  (pmem_read_d),
        .pmem_write_d (pmem_write_d),
        .pmem_addr_d  (pmem_addr_d),
        .pmem_wdata_d (pmem_wdata_d),
        .pmem_rdata_d (pmem_rdata_d),
        .pmem_resp_d  (pmem_resp_d),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drop_all();
        pmem_read_a  = 1'b0;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
        pmem_resp    = 1'b0;
        pmem_rdata   = '0;
    endtask

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            lat;
        bit            exp_read;
        bit            exp_write;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wdata;
        bit            exp_resp_a;
        bit            exp_resp_d;
        logic [LW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    // One isolated transaction; requester inputs are scrambled once granted.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.is_d) begin
            pmem_read_d  = !v.wr;
            pmem_write_d = v.wr;
            pmem_addr_d  = v.addr;
            pmem_wdata_d = v.wdata;
        end else begin
            pmem_read_a = 1'b1;
            pmem_addr_a = v.addr;
        end
        #1;
        chk("vec_idle_strobes", {pmem_read, pmem_write}, 2'b00);
        for (int k = 0; k <= v.lat; k++) begin
            @(negedge clk);
            pmem_addr_a  = 32'hbeef_0000;
            pmem_addr_d  = 32'hdead_0000;
            pmem_wdata_d = '1;
            if (k == v.lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = v.rdata;
            end
            #1;
            chk("vec_read", pmem_read, v.exp_read);
            chk("vec_write", pmem_write, v.exp_write);
            chk("vec_address", pmem_address, v.exp_addr);
            chk("vec_wdata", pmem_wdata, v.exp_wdata);
            chk("vec_resp_a", pmem_resp_a, (k == v.lat) && v.exp_resp_a);
            chk("vec_resp_d", pmem_resp_d, (k == v.lat) && v.exp_resp_d);
            chk("vec_rdata_a", pmem_rdata_a, ((k == v.lat) && v.exp_resp_a) ? v.exp_rdata : '0);
            chk("vec_rdata_d", pmem_rdata_d, ((k == v.lat) && v.exp_resp_d) ? v.exp_rdata : '0);
        end
        @(negedge clk);
        drop_all();
        #1;
        chk("vec_after_resp_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("vec_after_resp_resps", {pmem_resp_a, pmem_resp_d}, 2'b00);
        @(negedge clk);
    endtask

    // Random-phase reference: transaction-level view of caches, memory and the grant rule.
    bit            m_busy, m_side_d, m_wr, m_last_d;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    int            m_resp_cyc, m_gate, n_txn;
    bit            a_req, d_req, d_wr, a_done, d_done, a_gnt, d_gnt;
    int            a_cool, d_cool;
    logic [AW-1:0] a_addr, d_addr;
    logic [LW-1:0] d_wdata;

    initial begin
        vecs[0] = '{0, 0, 32'h60,  '0, {32{8'hA5}}, 4,
                    1, 0, 32'h60,  '0, 1, 0, {32{8'hA5}}};
        vecs[1] = '{1, 1, 32'h100, {8{32'h1234_5678}}, {8{32'h0bad_f00d}}, 3,
                    0, 1, 32'h100, {8{32'h1234_5678}}, 0, 1, {8{32'h0bad_f00d}}};
        vecs[2] = '{1, 0, 32'h200, {8{32'hffff_ffff}}, {8{32'hc0de_0002}}, 1,
                    1, 0, 32'h200, '0, 0, 1, {8{32'hc0de_0002}}};
        vecs[3] = '{0, 0, 32'h20,  '0, {8{32'h5a5a_0020}}, 0,
                    1, 0, 32'h20,  '0, 1, 0, {8{32'h5a5a_0020}}};

        rst = 1'b0;
        drop_all();
        pmem_addr_a  = '0;
        pmem_addr_d  = '0;
        pmem_wdata_d = '0;
        #1 rst = 1'b1;
        pmem_resp  = 1'b1;
        pmem_rdata = '1;
        pmem_read_a = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("rst_address", pmem_address, '0);
        chk("rst_wdata", pmem_wdata, '0);
        chk("rst_resps", {pmem_resp_a, pmem_resp_d}, 2'b00);
        chk("rst_rdata_a", pmem_rdata_a, '0);
        chk("rst_rdata_d", pmem_rdata_d, '0);
        @(negedge clk);
        drop_all();
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Simultaneous requests: dcache first, icache strobe 3 cycles after dcache resp.
        @(negedge clk);
        pmem_read_a = 1'b1; pmem_addr_a = 32'h40;
        pmem_read_d = 1'b1; pmem_addr_d = 32'h80;
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = {8{32'h0000_0080}};
        #1;
        chk("tie_first_addr", pmem_address, 32'h80);
        chk("tie_first_resp_d", pmem_resp_d, 1'b1);
        chk("tie_first_resp_a", pmem_resp_a, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0; pmem_read_d = 1'b0;
        #1 chk("tie_recover_strobe", pmem_read, 1'b0);
        @(negedge clk);
        #1 chk("tie_idle_strobe", pmem_read, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = {8{32'h0000_0040}};
        #1;
        chk("tie_second_read", pmem_read, 1'b1);
        chk("tie_second_addr", pmem_address, 32'h40);
        chk("tie_second_rdata_a", pmem_rdata_a, {8{32'h0000_0040}});
        @(negedge clk);
        drop_all();
        @(negedge clk);

        // Spurious memory response while idle.
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = '1;
        #1;
        chk("spurious_resps", {pmem_resp_a, pmem_resp_d}, 2'b00);
        chk("spurious_rdata_d", pmem_rdata_d, '0);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1 chk("spurious_strobes", {pmem_read, pmem_write}, 2'b00);

        // Illegal read+write from dcache: the write wins.
        @(negedge clk);
        pmem_read_d = 1'b1; pmem_write_d = 1'b1;
        pmem_addr_d = 32'h300; pmem_wdata_d = {8{32'h3300_0033}};
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = {8{32'h7777_0000}};
        #1;
        chk("both_write", pmem_write, 1'b1);
        chk("both_read", pmem_read, 1'b0);
        chk("both_wdata", pmem_wdata, {8{32'h3300_0033}});
        chk("both_resp_d", pmem_resp_d, 1'b1);
        @(negedge clk);
        drop_all();
        @(negedge clk);

        // Reset while busy on an icache fill.
        @(negedge clk);
        pmem_read_a = 1'b1; pmem_addr_a = 32'h400;
        @(negedge clk);
        #1 chk("midrst_busy_read", pmem_read, 1'b1);
        #1 rst = 1'b1; pmem_resp = 1'b1; pmem_rdata = '1;
        #1;
        chk("midrst_read", pmem_read, 1'b0);
        chk("midrst_address", pmem_address, '0);
        chk("midrst_resp_a", pmem_resp_a, 1'b0);
        chk("midrst_rdata_a", pmem_rdata_a, '0);
        @(negedge clk);
        rst = 1'b0;
        drop_all();
        @(negedge clk);
        run_vec(vecs[3]);

        // Random traffic; reset first so the round-robin flag is known.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 0; m_last_d = 0; m_gate = 0; n_txn = 0;
        a_req = 0; d_req = 0; a_done = 0; d_done = 0; a_gnt = 0; d_gnt = 0;
        a_cool = 0; d_cool = 0; d_wr = 0;
        a_addr = '0; d_addr = '0; d_wdata = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            pmem_resp  = m_busy && (c == m_resp_cyc);
            pmem_rdata = pmem_resp ? rand_line() : '0;
            if (a_done) begin
                a_req = 0; a_done = 0; a_cool = 1;
            end else if (!a_req && a_cool > 0) begin
                a_cool--;
            end else if (!a_req && $urandom_range(2) == 0) begin
                a_req = 1; a_addr = $urandom() & ~32'h1f;
            end
            if (d_done) begin
                d_req = 0; d_done = 0; d_cool = 1;
            end else if (!d_req && d_cool > 0) begin
                d_cool--;
            end else if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1; d_wr = $urandom_range(1) == 1;
                d_addr = $urandom() & ~32'h1f; d_wdata = rand_line();
            end
            pmem_read_a  = a_req;
            pmem_addr_a  = a_gnt ? $urandom() : a_addr;
            pmem_read_d  = d_req && !d_wr;
            pmem_write_d = d_req && d_wr;
            pmem_addr_d  = d_gnt ? $urandom() : d_addr;
            pmem_wdata_d = d_gnt ? rand_line() : d_wdata;
            #1;
            chk("rnd_read", pmem_read, m_busy && !m_wr);
            chk("rnd_write", pmem_write, m_busy && m_wr);
            if (m_busy) begin
                chk("rnd_address", pmem_address, m_addr);
                chk("rnd_wdata", pmem_wdata, m_wr ? m_wdata : '0);
            end
            chk("rnd_resp_a", pmem_resp_a, pmem_resp && !m_side_d);
            chk("rnd_resp_d", pmem_resp_d, pmem_resp && m_side_d);
            chk("rnd_rdata_a", pmem_rdata_a, (pmem_resp && !m_side_d) ? pmem_rdata : '0);
            chk("rnd_rdata_d", pmem_rdata_d, (pmem_resp && m_side_d) ? pmem_rdata : '0);
            if (pmem_resp) begin
                m_busy = 0;
                m_gate = c + 2;
                n_txn++;
                if (m_side_d) begin d_done = 1; d_gnt = 0; end
                else begin a_done = 1; a_gnt = 0; end
            end else if (!m_busy && c >= m_gate && (a_req || d_req)) begin
`ifdef PMEM_ARB_RR_EN
                m_side_d = d_req && !(a_req && m_last_d);
`else
                m_side_d = d_req;
`endif
                m_last_d   = m_side_d;
                m_wr       = m_side_d && d_wr;
                m_addr     = m_side_d ? d_addr : a_addr;
                m_wdata    = d_wdata;
                m_busy     = 1;
                m_resp_cyc = c + 1 + $urandom_range(4);
                if (m_side_d) d_gnt = 1; else a_gnt = 1;
            end
        end
        chk("rnd_txn_progress", n_txn > 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
